// File: rtl/trash_cpu_pkg.sv
// Shared types and constants for the trash_cpu core: opcodes, ALU codes,
// FSM states and instruction field positions.
package trash_cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ALU  = 4'h2,
    OP_ST   = 4'h3,
    OP_LD   = 4'h4,
    OP_JMP  = 4'h5,
    OP_JEQ  = 4'h6,
    OP_OUT  = 4'h7,
    OP_HALT = 4'h8
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_MUL  = 4'h2,
    ALU_DIV  = 4'h3,
    ALU_MOD  = 4'h4,
    ALU_AND  = 4'h5,
    ALU_OR   = 4'h6,
    ALU_XOR  = 4'h7,
    ALU_NOT  = 4'h8,
    ALU_SHR  = 4'h9,
    ALU_SHL  = 4'hA,
    ALU_INC  = 4'hB,
    ALU_DEC  = 4'hC,
    ALU_PASS = 4'hD,
    ALU_EQ   = 4'hE,
    ALU_LTU  = 4'hF
  } alu_code_t;

  localparam int OP_LSB  = 12;
  localparam int A_LSB   = 8;
  localparam int B_LSB   = 4;
  localparam int C_LSB   = 0;
  localparam int IMM_LSB = 0;
  localparam int FIELD_W = 4;
  localparam int IMM_W   = 8;

  function automatic logic is_muldiv(input alu_code_t code);
    return (code == ALU_MUL) || (code == ALU_DIV) || (code == ALU_MOD);
  endfunction

endpackage

// File: rtl/trash_cpu_alu.sv
// Combinational 8-bit ALU. mul/div/mod exist only when TRASH_CPU_MULDIV_EN
// is defined; otherwise those codes produce 0.
module trash_cpu_alu
  import trash_cpu_pkg::*;
(
  input  alu_code_t  code,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] result
);

  always_comb begin
    result = '0;
    case (code)
      ALU_ADD:  result = x + y;
      ALU_SUB:  result = x - y;
`ifdef TRASH_CPU_MULDIV_EN
      ALU_MUL:  result = x * y;
      ALU_DIV:  result = (y == 8'd0) ? 8'hFF : (x / y);
      ALU_MOD:  result = (y == 8'd0) ? x : (x % y);
`endif
      ALU_AND:  result = x & y;
      ALU_OR:   result = x | y;
      ALU_XOR:  result = x ^ y;
      ALU_NOT:  result = ~x;
      ALU_SHR:  result = x >> 1;
      ALU_SHL:  result = x << 1;
      ALU_INC:  result = x + 8'd1;
      ALU_DEC:  result = x - 8'd1;
      ALU_PASS: result = y;
      ALU_EQ:   result = {7'd0, (x == y)};
      ALU_LTU:  result = {7'd0, (x < y)};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/trash_cpu.sv
// Tiny single-cycle 8-bit CPU with writable program store and IDLE/RUN/HALT
// control. Optional mul/div/mod ALU ops: define TRASH_CPU_MULDIV_EN.
module trash_cpu
  import trash_cpu_pkg::*;
#(
  parameter int PROG_DEPTH = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int NUM_REGS   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [15:0] prog_data,
  input  logic        run,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  localparam int PW = $clog2(PROG_DEPTH);
  localparam int MW = $clog2(MEM_DEPTH);
  localparam int RW = $clog2(NUM_REGS);

  state_t        state_reg, state_next;
  logic [PW-1:0] pc_reg, pc_next;
  logic [7:0]    regs_reg [NUM_REGS];
  logic [7:0]    mem_reg  [MEM_DEPTH];
  logic [15:0]   prog_mem [PROG_DEPTH];
  logic [7:0]    out_data_reg;
  logic          out_valid_reg;
  logic          illegal_reg;

  logic [15:0]   instr;
  logic [3:0]    op;
  alu_code_t     alu_code;
  logic [RW-1:0] ra, rb, rc;
  logic [MW-1:0] ma;
  logic [PW-1:0] pa;
  logic [7:0]    imm, x, y, alu_result;
  logic          step, start, prog_wr, alu_unsupported;
  logic          reg_we, mem_we, out_fire, halt_fire, illegal_fire;
  logic [RW-1:0] reg_wa;
  logic [7:0]    reg_wd;
  logic          unused_bits;

  assign start   = ena && run && (state_reg != ST_RUN);
  assign step    = ena && (state_reg == ST_RUN);
  // run wins over a simultaneous program write
  assign prog_wr = ena && prog_we && !run && (state_reg != ST_RUN);

  assign instr    = prog_mem[pc_reg];
  assign op       = instr[OP_LSB +: FIELD_W];
  assign alu_code = alu_code_t'(instr[A_LSB +: FIELD_W]);
  assign ra       = instr[A_LSB +: RW];
  assign rb       = instr[B_LSB +: RW];
  assign rc       = instr[C_LSB +: RW];
  assign ma       = instr[A_LSB +: MW];
  assign pa       = instr[A_LSB +: PW];
  assign imm      = instr[IMM_LSB +: IMM_W];
  assign x        = regs_reg[rb];
  assign y        = regs_reg[rc];
  assign unused_bits = ^{prog_addr, instr};

`ifdef TRASH_CPU_MULDIV_EN
  assign alu_unsupported = 1'b0;
`else
  assign alu_unsupported = is_muldiv(alu_code);
`endif

  trash_cpu_alu u_alu (
    .code   (alu_code),
    .x      (x),
    .y      (y),
    .result (alu_result)
  );

  always_comb begin
    pc_next      = pc_reg + PW'(1);
    reg_we       = 1'b0;
    reg_wa       = rb;
    reg_wd       = alu_result;
    mem_we       = 1'b0;
    out_fire     = 1'b0;
    halt_fire    = 1'b0;
    illegal_fire = 1'b0;
    if (step) begin
      case (op)
        OP_NOP: begin end
        OP_LDI: begin
          reg_we = 1'b1;
          reg_wa = ra;
          reg_wd = imm;
        end
        OP_ALU: begin
          reg_we       = 1'b1;
          illegal_fire = alu_unsupported;
        end
        OP_ST:  mem_we = 1'b1;
        OP_LD: begin
          reg_we = 1'b1;
          reg_wd = mem_reg[ma];
        end
        OP_JMP: pc_next = pa;
        OP_JEQ: if (x == y) pc_next = pa;
        OP_OUT: out_fire = 1'b1;
        OP_HALT: begin
          halt_fire = 1'b1;
          pc_next   = pc_reg;
        end
        default: illegal_fire = 1'b1;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    if (ena) begin
      case (state_reg)
        ST_IDLE, ST_HALT: if (run) state_next = ST_RUN;
        ST_RUN:           if (halt_fire) state_next = ST_HALT;
        default:          state_next = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy   = (state_reg == ST_RUN);
    halted = (state_reg == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pc_reg <= '0;
    else if (start) pc_reg <= '0;
    else if (step)  pc_reg <= pc_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
    end else if (reg_we) begin
      regs_reg[reg_wa] <= reg_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_reg[i] <= '0;
    end else if (mem_we) begin
      mem_reg[ma] <= x;
    end
  end

  // Program store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (prog_wr) prog_mem[prog_addr[PW-1:0]] <= prog_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      out_valid_reg <= out_fire;
      if (out_fire) out_data_reg <= regs_reg[ra];
      if (illegal_fire) illegal_reg <= 1'b1;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_trash_cpu.sv
// Self-checking bench for trash_cpu: directed programs plus random programs,
// all compared against an instruction-level reference model.
module tb_trash_cpu;

  localparam int PD = 8;
  localparam int MD = 16;
  localparam int NR = 4;
`ifdef TRASH_CPU_MULDIV_EN
  localparam bit MULDIV_ON = 1'b1;
`else
  localparam bit MULDIV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, ena, prog_we, run;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic [7:0]  out_data;
  logic        out_valid, busy, halted, illegal;

  trash_cpu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .run       (run),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] pgm    [PD];
  logic [15:0] m_prog [PD];
  int          m_regs [NR];
  int          m_mem  [MD];
  int          m_outs [$];
  int          d_outs [$];
  bit          m_ill, m_halted;
  int          m_out_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 0;
    for (int i = 0; i < MD; i++) m_mem[i] = 0;
    m_ill = 1'b0;
    m_halted = 1'b0;
    m_out_last = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic int alu_ref(input int code, input int x, input int y);
    int r;
    case (code)
      0:  r = x + y;
      1:  r = x - y + 256;
      2:  r = MULDIV_ON ? x * y : 0;
      3:  r = MULDIV_ON ? ((y == 0) ? 255 : x / y) : 0;
      4:  r = MULDIV_ON ? ((y == 0) ? x : x % y) : 0;
      5:  r = x & y;
      6:  r = x | y;
      7:  r = x ^ y;
      8:  r = 255 - x;
      9:  r = x / 2;
      10: r = x * 2;
      11: r = x + 1;
      12: r = x + 255;
      13: r = y;
      14: r = (x == y) ? 1 : 0;
      default: r = (x < y) ? 1 : 0;
    endcase
    return r % 256;
  endfunction

  // Instruction-level model: execute up to n instructions from PC 0.
  task automatic model_run(input int n);
    int pc, nxt, op, a, b, c, imm, x, y;
    logic [15:0] w;
    pc = 0;
    m_halted = 1'b0;
    m_outs.delete();
    for (int s = 0; s < n; s++) begin
      if (m_halted) break;
      w   = m_prog[pc];
      op  = int'(w[15:12]);
      a   = int'(w[11:8]);
      b   = int'(w[7:4]);
      c   = int'(w[3:0]);
      imm = int'(w[7:0]);
      x   = m_regs[b % NR];
      y   = m_regs[c % NR];
      nxt = (pc + 1) % PD;
      case (op)
        0: ;
        1: m_regs[a % NR] = imm;
        2: begin
          m_regs[b % NR] = alu_ref(a, x, y);
          if (!MULDIV_ON && a >= 2 && a <= 4) m_ill = 1'b1;
        end
        3: m_mem[a % MD] = x;
        4: m_regs[b % NR] = m_mem[a % MD];
        5: nxt = a % PD;
        6: if (x == y) nxt = a % PD;
        7: begin
          m_outs.push_back(m_regs[a % NR]);
          m_out_last = m_regs[a % NR];
        end
        8: begin
          m_halted = 1'b1;
          nxt = pc;
        end
        default: m_ill = 1'b1;
      endcase
      pc = nxt;
    end
  endtask

  task automatic load_from(input int lo);
    for (int i = lo; i < PD; i++) begin
      prog_we = 1'b1;
      prog_addr = 4'(i);
      prog_data = pgm[i];
      tick();
      m_prog[i] = pgm[i];
    end
    prog_we = 1'b0;
  endtask

  // Start the DUT and let it execute up to n instructions (bounded).
  task automatic dut_run(input int n, input bit gap, input bit we_with_run);
    int cyc;
    bit gapped;
    cyc = 0;
    gapped = 1'b0;
    d_outs.delete();
    run = 1'b1;
    if (we_with_run) begin
      prog_we = 1'b1;
      prog_addr = 4'd5;
      prog_data = 16'h7000;
    end
    tick();
    run = 1'b0;
    prog_we = 1'b0;
    while (cyc < n && !halted) begin
      if (gap && cyc == 3 && !gapped) begin
        ena = 1'b0;
        run = 1'b1;
        repeat (4) begin
          tick();
          if (out_valid) d_outs.push_back(int'(out_data));
        end
        run = 1'b0;
        ena = 1'b1;
        gapped = 1'b1;
      end
      tick();
      cyc++;
      if (out_valid) d_outs.push_back(int'(out_data));
    end
  endtask

  task automatic compare_run(input string tag);
    check({tag, "_nouts"}, d_outs.size(), m_outs.size());
    for (int i = 0; i < m_outs.size() && i < d_outs.size(); i++)
      check($sformatf("%s_out%0d", tag, i), d_outs[i], m_outs[i]);
    check({tag, "_halted"}, halted, m_halted);
    check({tag, "_busy"}, busy, !m_halted);
    check({tag, "_illegal"}, illegal, m_ill);
    check({tag, "_out_data"}, out_data, m_out_last);
    $display("[TB] %s: outs=%0d halted=%0b illegal=%0b out_data=%02h",
             tag, d_outs.size(), halted, illegal, out_data);
  endtask

  initial begin
    logic [31:0] rv;
    int op;
    rst_n = 1'b1;
    ena = 1'b1;
    run = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();

    // add: 5 + 3
    pgm = '{16'h1005, 16'h1103, 16'h2010, 16'h7100, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
    load_from(0);
    model_run(20);
    dut_run(20, 1'b0, 1'b0);
    compare_run("add");
    check("add_value", d_outs.size() == 1 ? d_outs[0] : -1, 8);

    // store / load round trip, restarted from HALT
    pgm = '{16'h1007, 16'h3200, 16'h4230, 16'h7300, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
    load_from(0);
    model_run(20);
    dut_run(20, 1'b0, 1'b0);
    compare_run("stld");
    check("stld_value", out_data, 8'h07);

    // JEQ counting loop, with an ena-low freeze in the middle
    pgm = '{16'h1000, 16'h1104, 16'h2B00, 16'h7000, 16'h6601, 16'h5200, 16'h8000, 16'h0000};
    load_from(0);
    model_run(60);
    dut_run(60, 1'b1, 1'b0);
    compare_run("loop");
    check("loop_count", d_outs.size(), 4);

    // division by zero
    pgm = '{16'h1009, 16'h1100, 16'h2301, 16'h7000, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
    load_from(0);
    model_run(20);
    dut_run(20, 1'b0, 1'b0);
    compare_run("div0");
    check("div0_value", out_data, MULDIV_ON ? 8'hFF : 8'h00);
    check("div0_illegal", illegal, !MULDIV_ON);

    // undefined opcode
    do_reset();
    pgm = '{16'h9123, 16'h7000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    load_from(0);
    model_run(20);
    dut_run(20, 1'b0, 1'b0);
    compare_run("illop");
    check("illop_flag", illegal, 1);

    // write during RUN is dropped; reset mid-RUN clears state
    do_reset();
    pgm = '{16'h7200, 16'h1255, 16'h5000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    load_from(0);
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (3) tick();
    check("midrun_busy", busy, 1);
    prog_we = 1'b1;
    prog_addr = 4'd0;
    prog_data = 16'h8000;
    tick();
    prog_we = 1'b0;
    tick();
    rst_n = 1'b0;
    #2;
    model_reset();
    check("midrst_busy", busy, 0);
    check("midrst_halted", halted, 0);
    check("midrst_out_data", out_data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    pgm = '{16'h0000, 16'h7000, 16'h7100, 16'h7200, 16'h7300, 16'h8000, 16'h0000, 16'h0000};
    load_from(1);
    model_run(20);
    dut_run(20, 1'b0, 1'b1);
    compare_run("postrst");
    check("postrst_nouts", d_outs.size(), 5);

    // NOP program without HALT: PC wraps and busy stays high
    do_reset();
    pgm = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    load_from(0);
    run = 1'b1;
    tick();
    run = 1'b0;
    check("wrap_pc0", dut.pc_reg, 0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      check($sformatf("wrap_pc%0d", k), dut.pc_reg, k % PD);
      check($sformatf("wrap_busy%0d", k), busy, 1);
    end
    $display("[TB] wrap: pc=%0d busy=%0b", dut.pc_reg, busy);

    // random programs
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int i = 0; i < PD; i++) begin
        rv = $urandom();
        op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
        pgm[i] = {op[3:0], rv[11:0]};
      end
      load_from(0);
      model_run(40);
      dut_run(40, 1'b0, 1'b0);
      compare_run($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trash_cpu.md
TRASH_CPU -- requirements
Module: trash_cpu

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 8: program words; power of two, 2..16.
REQ-002 SHALL have parameter MEM_DEPTH, default 16: data-memory bytes; power of two, 2..16.
REQ-003 SHALL have parameter NUM_REGS, default 4: 8-bit general registers; power of two, 2..16.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ena  input  1  when low, state is frozen and prog_we/run are ignored.
REQ-007 SHALL have port prog_we  input  1  program-word write strobe.
REQ-008 SHALL have port prog_addr  input  4  program write address, taken modulo PROG_DEPTH.
REQ-009 SHALL have port prog_data  input  16  instruction word to write.
REQ-010 SHALL have port run  input  1  start execution from PC 0.
REQ-011 SHALL have port out_data  output  8  last value emitted by OUT.
REQ-012 SHALL have port out_valid  output  1  one-cycle pulse per executed OUT.
REQ-013 SHALL have port busy  output  1  high in RUN.
REQ-014 SHALL have port halted  output  1  high in HALT.
REQ-015 SHALL have port illegal  output  1  sticky: an undefined opcode was executed.

Function
REQ-016 SHALL implement states IDLE, RUN, HALT; IDLE->RUN on run; RUN->HALT on HALT instruction; HALT->RUN on run.
REQ-017 SHALL accept prog_we only in IDLE or HALT; writes in RUN are dropped.
REQ-018 SHALL, on entering RUN, set PC=0 and keep registers, memory, out_data.
REQ-019 SHALL execute one instruction per enabled cycle in RUN; results visible the next cycle.
REQ-020 SHALL decode word as op[15:12], a[11:8], b[7:4], c[3:0], imm=[7:0]; register/address fields taken modulo NUM_REGS/MEM_DEPTH/PROG_DEPTH.
REQ-021 SHALL support ops: 0 NOP; 1 LDI R[a]=imm; 2 ALU R[b]=R[b] op(a) R[c]; 3 ST M[a]=R[b]; 4 LD R[b]=M[a]; 5 JMP PC=a; 6 JEQ PC=a if R[b]==R[c]; 7 OUT out_data=R[a], out_valid=1; 8 HALT.
REQ-022 SHALL treat ops 9..15 as NOP and set illegal.
REQ-023 SHALL provide ALU codes 0 add,1 sub,2 mul,3 div,4 mod,5 and,6 or,7 xor,8 not x,9 shr1,A shl1,B inc,C dec,D pass y,E eq,F ltu; results 8 bits, wrapping; eq/ltu yield 1 or 0.
REQ-024 SHALL return 0xFF for div by zero and x for mod by zero.
REQ-025 SHALL wrap PC from PROG_DEPTH-1 to 0 for sequential advance.
REQ-026 SHALL give run priority over prog_we when both are asserted in IDLE/HALT; the write is dropped.
REQ-027 SHALL ignore run while in RUN.

Reset
REQ-028 SHALL on rst_n low force IDLE, PC=0, all registers and data memory 0, out_data=0, out_valid=0, busy=0, halted=0, illegal=0.
REQ-029 SHALL not clear program memory on reset; its contents are undefined until written.
REQ-030 SHALL abort execution immediately on reset mid-RUN with no partial write-back.

Configuration
REQ-031 SHALL compile ALU codes 2, 3, 4 (mul/div/mod) only when TRASH_CPU_MULDIV_EN is defined.
REQ-032 SHALL, without TRASH_CPU_MULDIV_EN, return 0 for ALU codes 2, 3, 4 and set illegal.

Structure
REQ-033 SHALL place opcode, ALU-code, and state enums plus field-position constants in package trash_cpu_pkg.
REQ-034 SHALL implement the ALU as combinational sub-module trash_cpu_alu (code, x, y -> 8-bit result).

Verification
REQ-035 SHALL cover: program LDI R0=5; LDI R1=3; ALU add R1=R1+R0; OUT R1; HALT, then run -> out_data=0x08 with one out_valid pulse, then halted=1.
REQ-036 SHALL cover: LDI R0=7; ST M[2]=R0; LD R3=M[2]; OUT R3; HALT -> out_data=0x07.
REQ-037 SHALL cover: JEQ loop counting R0 from 0 by inc until R0==R1=4, OUT each pass -> out_data sequence 1,2,3,4, then HALT.
REQ-038 SHALL cover: ALU div 9/0 -> 0xFF with macro defined; same program without macro -> 0x00 and illegal=1.
REQ-039 SHALL cover: prog_we during RUN and rst_n pulse mid-RUN -> program word unchanged, state IDLE, all registers read 0 on a later run.
REQ-040 SHALL cover: 8-NOP program with no HALT at PROG_DEPTH=8 -> PC wraps 7->0, busy stays 1.
